// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer and a two-state IDLE/GRANT FSM.
// Optional hold-time watchdog compiled in by defining RING_ARB_TIMEOUT_EN.
module ring_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic             done_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] ptr_o,
    output logic             timeout_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] gnt_q;
    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] ptr_rel_d;
    logic             rel_d;
    logic             found_d;
    int               ptr_idx_d;

    if (WIDTH < 2) begin : g_bad_width
        $error("ring_rr_arbiter: WIDTH must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("ring_rr_arbiter: MAX_HOLD must be >= 2");
    end

    // Pick the first requester at or after the pointer, scanning the ring twice to cover the wrap.
    always_comb begin
        ptr_idx_d = 0;
        sel_d     = '0;
        found_d   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ptr_idx_d = ptr_q[i] ? i : ptr_idx_d;
        end
        for (int k = 0; k < 2 * WIDTH; k++) begin
            sel_d[k % WIDTH] = sel_d[k % WIDTH] |
                               (!found_d && (k >= ptr_idx_d) && req_i[k % WIDTH]);
            found_d          = found_d | ((k >= ptr_idx_d) && req_i[k % WIDTH]);
        end
    end

    // Normal release condition and the post-release pointer (one past the holder).
    always_comb begin
        rel_d     = done_i | ~(|(req_i & gnt_q));
        ptr_rel_d = {gnt_q[WIDTH-2:0], gnt_q[WIDTH-1]};
    end

`ifdef RING_ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Arbitration FSM with hold counter; a normal release outranks the watchdog.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    cnt_q     <= '0;
                    if (|req_i) begin
                        gnt_q   <= sel_d;
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (rel_d) begin
                        gnt_q     <= '0;
                        ptr_q     <= ptr_rel_d;
                        state_q   <= IDLE;
                        timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                        gnt_q     <= '0;
                        ptr_q     <= ptr_rel_d;
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gnt_q     <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_o = timeout_q;
`else
    // Arbitration FSM without watchdog; a grant lasts until done or request drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        gnt_q   <= sel_d;
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (rel_d) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_rel_d;
                        state_q <= IDLE;
                    end else begin
                        gnt_q   <= gnt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign gnt_o  = gnt_q;
    assign ptr_o  = ptr_q;
    assign busy_o = (state_q == GRANT);

endmodule

// File: doc/ring_rr_arbiter.md
RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, number of requesters (>= 2).
REQ-002 Parameter MAX_HOLD, default 16, max grant cycles before forced release (>= 2).
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 req_i  input  WIDTH  per-requester request, level, bit i = requester i.
REQ-006 done_i  input  1  current grant holder finished; sampled only in GRANT.
REQ-007 gnt_o  output  WIDTH  one-hot grant, registered; all-zero when none.
REQ-008 busy_o  output  1  high while FSM in GRANT.
REQ-009 ptr_o  output  WIDTH  one-hot ring priority pointer, registered.
REQ-010 timeout_o  output  1  one-cycle pulse on forced release; constant 0 when feature compiled out.

Function
REQ-011 FSM states SHALL be IDLE and GRANT only.
REQ-012 Pointer SHALL always be one-hot; it rotates left by position, wrapping bit WIDTH-1 to bit 0.
REQ-013 In IDLE with req_i != 0: select first set req_i bit at or after the ptr_o position, circular order; gnt_o = that bit next cycle, state -> GRANT (latency 1 cycle).
REQ-014 In IDLE with req_i == 0: gnt_o stays 0; done_i ignored.
REQ-015 In GRANT, gnt_o SHALL hold constant; req_i changes on other bits SHALL NOT affect it.
REQ-016 Release SHALL occur on the edge where, in GRANT, done_i = 1 OR the granted requester's req_i bit = 0.
REQ-017 On release: gnt_o -> 0, busy_o -> 0, state -> IDLE, ptr_o -> one-hot bit just after the released grant index (index WIDTH-1 wraps to bit 0).
REQ-018 After release, at least one IDLE cycle with gnt_o = 0 SHALL precede the next grant.
REQ-019 Simultaneous done_i and req drop SHALL count as a single release.
REQ-020 ptr_o SHALL change only on release or reset.
REQ-021 gnt_o SHALL never have more than one bit set.

Reset
REQ-022 rst_i high SHALL asynchronously force: state IDLE, gnt_o = 0, busy_o = 0, ptr_o = bit 0 set, timeout_o = 0, hold counter = 0.
REQ-023 Reset during GRANT SHALL drop gnt_o immediately, with no release side effects.
REQ-024 First grant SHALL be possible on the first rising edge after rst_i deasserts.

Configuration
REQ-025 Macro RING_ARB_TIMEOUT_EN SHALL, when defined, compile in the hold counter and watchdog.
REQ-026 With it defined: the counter clears on entry to GRANT and increments each GRANT cycle; after gnt_o has been high MAX_HOLD cycles with no release, force a release per REQ-017 and pulse timeout_o for 1 cycle.
REQ-027 With it defined, a normal release SHALL take precedence over a timeout in the same cycle, and timeout_o stays 0.
REQ-028 Without it: no counter is present, timeout_o is tied 0, and a grant may be held indefinitely.

Verification (WIDTH=4, MAX_HOLD=16)
REQ-029 Assert rst_i mid-run -> gnt_o=0000, ptr_o=0001, busy_o=0, timeout_o=0 without a clock edge.
REQ-030 req_i=1111 held, done_i pulsed 2 cycles after each grant -> grants 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
REQ-031 ptr_o=0100, req_i=0011 -> gnt_o=0001 (wrap), after done ptr_o=0010.
REQ-032 Grant 0010 held, req_i[1] dropped -> gnt_o=0000 next edge, ptr_o=0100, timeout_o=0.
REQ-033 With RING_ARB_TIMEOUT_EN: req_i=0010, done_i=0 -> gnt_o=0010 for exactly 16 cycles, then gnt_o=0000 and timeout_o=1 for one cycle; without the macro, the grant persists past 100 cycles.
REQ-034 Same cycle done_i=1 and a new req_i bit rises -> release first, new grant appears after the idle cycle, and a one-hot check holds throughout.
